conf_burst_sequencer: RTL and testbench

//  Consumes one job from the AXI-lite config block (CONFIG_VALID/READY/DATA) and splits it into AXI3 burst commands.

---
 rtl/conf_burst_sequencer_pkg.sv | 25 ++
 rtl/conf_burst_sequencer_addr_gen.sv | 102 ++++++++++
 rtl/conf_burst_sequencer.sv | 135 +++++++++++++
 tb/tb_conf_burst_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conf_burst_sequencer_pkg.sv
// Shared definitions for the config-job burst sequencer.
//   - CMD register bit positions (read / write enable)
//   - CONFIG_DATA register indices
//   - job state enum
//   - 4KB page constants (AXI bursts must not cross a 4KB boundary)
package conf_burst_sequencer_pkg;

  localparam int CMD_RD_BIT = 0;
  localparam int CMD_WR_BIT = 1;

  localparam int REG_CMD = 0;
  localparam int REG_SRC = 1;
  localparam int REG_DST = 2;
  localparam int REG_LEN = 3;

  localparam int PAGE_SH    = 12;
  localparam int PAGE_BYTES = 1 << PAGE_SH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } job_state_e;

endpackage

// File: rtl/conf_burst_sequencer_addr_gen.sv
// One side (read or write) of the burst sequencer: walks a byte range in
// AXI3 bursts, keeps up to MAX_OUTST bursts in flight and reports when the
// whole range has been issued and acknowledged.
// Ports:
//   ACLK, ARESETN            clock, async active-low reset
//   load                     start a new range (job accepted into RUN)
//   load_addr, load_beats    range start byte address and length in beats
//                            (load_beats==0 leaves the side idle/complete)
//   cmd_valid/ready          burst command handshake
//   cmd_addr, cmd_len        burst start address, beats-1
//   done                     one-cycle pulse per completed burst
//   complete                 nothing left to issue and nothing in flight
module conf_burst_sequencer_addr_gen
  import conf_burst_sequencer_pkg::*;
#(
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BURST  = 16,
  parameter int MAX_OUTST  = 4,
  parameter int REM_W      = 32 - $clog2(BEAT_BYTES)
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             load,
  input  logic [31:0]      load_addr,
  input  logic [REM_W-1:0] load_beats,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [31:0]      cmd_addr,
  output logic [3:0]       cmd_len,
  input  logic             done,
  output logic             complete
);

  localparam int BEAT_SH = $clog2(BEAT_BYTES);
  localparam int OUT_W   = $clog2(MAX_OUTST + 1);
  localparam int BL_W    = $clog2(MAX_BURST) + 1;
  localparam int PW      = PAGE_SH + 1;

  logic [31:0]      addr_q, addr_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic [3:0]       len_q, len_d;
  logic             valid_q, valid_d;
  logic             hs, dec;
  logic [BL_W-1:0]  beats_now, beats_d;

  // Burst size = min(remaining, MAX_BURST, beats left in the current 4KB page).
  function automatic logic [BL_W-1:0] burst_beats(input logic [PAGE_SH-1:0] page_off,
                                                 input logic [REM_W-1:0]   rem);
    logic [PW-1:0] to_page;
    logic [PW-1:0] beats;
    to_page = (PW'(PAGE_BYTES) - {1'b0, page_off}) >> BEAT_SH;
    beats   = PW'(MAX_BURST);
    if (to_page < beats) beats = to_page;
    if (rem < REM_W'(beats)) beats = PW'(rem);
    return BL_W'(beats);
  endfunction

  always_comb begin
    hs        = valid_q && cmd_ready;
    // A completion with nothing in flight is stale (e.g. from before a reset).
    dec       = done && (outst_q != '0);
    beats_now = BL_W'(len_q) + BL_W'(1);
    addr_d    = addr_q;
    rem_d     = rem_q;
    outst_d   = outst_q + OUT_W'(hs) - OUT_W'(dec);
    if (load) begin
      addr_d  = load_addr;
      rem_d   = load_beats;
      outst_d = '0;
    end else if (hs) begin
      addr_d = addr_q + (32'(beats_now) << BEAT_SH);
      rem_d  = rem_q - REM_W'(beats_now);
    end
    // addr/rem only move on a handshake, so a stalled command stays stable.
    beats_d = burst_beats(addr_d[PAGE_SH-1:0], rem_d);
    len_d   = (beats_d == '0) ? 4'd0 : 4'(beats_d - BL_W'(1));
    valid_d = (rem_d != '0) && (outst_d < OUT_W'(MAX_OUTST));
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr_q  <= '0;
      rem_q   <= '0;
      outst_q <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      outst_q <= outst_d;
      len_q   <= len_d;
      valid_q <= valid_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_addr  = addr_q;
  assign cmd_len   = len_q;
  assign complete  = (rem_q == '0) && (outst_q == '0);

endmodule

// File: rtl/conf_burst_sequencer.sv
// Takes one job from the config block and splits it into AXI3 burst
// commands for the DRAM reader and writer. CONFIG_READY is low for the
// whole job; the config block times the job and raises its IRQ from that.
// Ports:
//   ACLK, ARESETN                 clock, async active-low reset
//   CONFIG_VALID/READY/DATA       job handshake; DATA = {LEN, DST, SRC, CMD}
//   RD_CMD_*, RD_DONE             read burst commands and completions
//   WR_CMD_*, WR_DONE             write burst commands and completions
//   JOB_ERR                       last accepted job was misaligned
module conf_burst_sequencer
  import conf_burst_sequencer_pkg::*;
#(
  parameter int NREG       = 4,
  parameter int W          = 32,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BURST  = 16,
  parameter int MAX_OUTST  = 4
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              CONFIG_VALID,
  output logic              CONFIG_READY,
  input  logic [NREG*W-1:0] CONFIG_DATA,
  output logic              RD_CMD_VALID,
  input  logic              RD_CMD_READY,
  output logic [31:0]       RD_CMD_ADDR,
  output logic [3:0]        RD_CMD_LEN,
  input  logic              RD_DONE,
  output logic              WR_CMD_VALID,
  input  logic              WR_CMD_READY,
  output logic [31:0]       WR_CMD_ADDR,
  output logic [3:0]        WR_CMD_LEN,
  input  logic              WR_DONE,
  output logic              JOB_ERR
);

  localparam int          BEAT_SH    = $clog2(BEAT_BYTES);
  localparam int          REM_W      = 32 - BEAT_SH;
  localparam logic [W-1:0] ALIGN_MASK = W'(BEAT_BYTES - 1);

  job_state_e       state_q, state_d;
  logic             job_err_q;
  logic [W-1:0]     cfg_cmd, cfg_src, cfg_dst, cfg_len;
  logic             rd_en, wr_en, cfg_err, cfg_empty, accept, load;
  logic [REM_W-1:0] rd_beats, wr_beats;
  logic             rd_complete, wr_complete;
  logic             unused_cmd_bits;

  assign cfg_cmd = CONFIG_DATA[REG_CMD*W +: W];
  assign cfg_src = CONFIG_DATA[REG_SRC*W +: W];
  assign cfg_dst = CONFIG_DATA[REG_DST*W +: W];
  assign cfg_len = CONFIG_DATA[REG_LEN*W +: W];
  assign unused_cmd_bits = ^cfg_cmd[W-1:2];

  assign rd_en = cfg_cmd[CMD_RD_BIT];
  assign wr_en = cfg_cmd[CMD_WR_BIT];

  // Alignment only matters for sides that will actually move data.
  assign cfg_err   = (rd_en && ((cfg_src & ALIGN_MASK) != '0)) ||
                     (wr_en && ((cfg_dst & ALIGN_MASK) != '0)) ||
                     ((rd_en || wr_en) && ((cfg_len & ALIGN_MASK) != '0));
  assign cfg_empty = (cfg_len == '0) || !(rd_en || wr_en);

  assign accept = CONFIG_VALID && (state_q == ST_IDLE);
  assign load   = accept && !cfg_err && !cfg_empty;

  // A disabled side is loaded with zero beats and so reports complete at once.
  assign rd_beats = rd_en ? REM_W'(cfg_len >> BEAT_SH) : '0;
  assign wr_beats = wr_en ? REM_W'(cfg_len >> BEAT_SH) : '0;

  always_comb begin
    state_d      = state_q;
    CONFIG_READY = 1'b0;
    case (state_q)
      ST_IDLE: begin
        CONFIG_READY = 1'b1;
        if (accept) state_d = (cfg_err || cfg_empty) ? ST_DONE : ST_RUN;
      end
      ST_RUN:  if (rd_complete && wr_complete) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      job_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) job_err_q <= cfg_err;
    end
  end

  assign JOB_ERR = job_err_q;

  conf_burst_sequencer_addr_gen #(
    .BEAT_BYTES (BEAT_BYTES),
    .MAX_BURST  (MAX_BURST),
    .MAX_OUTST  (MAX_OUTST),
    .REM_W      (REM_W)
  ) u_rd (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .load       (load),
    .load_addr  (32'(cfg_src)),
    .load_beats (rd_beats),
    .cmd_valid  (RD_CMD_VALID),
    .cmd_ready  (RD_CMD_READY),
    .cmd_addr   (RD_CMD_ADDR),
    .cmd_len    (RD_CMD_LEN),
    .done       (RD_DONE),
    .complete   (rd_complete)
  );

  conf_burst_sequencer_addr_gen #(
    .BEAT_BYTES (BEAT_BYTES),
    .MAX_BURST  (MAX_BURST),
    .MAX_OUTST  (MAX_OUTST),
    .REM_W      (REM_W)
  ) u_wr (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .load       (load),
    .load_addr  (32'(cfg_dst)),
    .load_beats (wr_beats),
    .cmd_valid  (WR_CMD_VALID),
    .cmd_ready  (WR_CMD_READY),
    .cmd_addr   (WR_CMD_ADDR),
    .cmd_len    (WR_CMD_LEN),
    .done       (WR_DONE),
    .complete   (wr_complete)
  );

endmodule

// File: tb/tb_conf_burst_sequencer.sv
// Bench for conf_burst_sequencer: directed jobs followed by randomized jobs.
// Expected bursts come from a list built by plain arithmetic on the job
// (min of remaining, 16, beats to next 4KB page); handshakes and completions
// are tracked as issued/outstanding counts.
module tb_conf_burst_sequencer;

  localparam int NREG = 4;
  localparam int W    = 32;
  localparam int BB   = 8;
  localparam int MAXB = 16;
  localparam int MAXO = 4;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic              CONFIG_VALID;
  logic              CONFIG_READY;
  logic [NREG*W-1:0] CONFIG_DATA;
  logic              RD_CMD_VALID, WR_CMD_VALID;
  logic [31:0]       RD_CMD_ADDR, WR_CMD_ADDR;
  logic [3:0]        RD_CMD_LEN, WR_CMD_LEN;
  logic              JOB_ERR;
  logic [1:0]        crdy, cdone;
  logic [1:0]        cv;
  logic [31:0]       ca [2];
  logic [3:0]        cl [2];

  always #5 ACLK = ~ACLK;

  assign cv    = {WR_CMD_VALID, RD_CMD_VALID};
  assign ca[0] = RD_CMD_ADDR;
  assign ca[1] = WR_CMD_ADDR;
  assign cl[0] = RD_CMD_LEN;
  assign cl[1] = WR_CMD_LEN;

  conf_burst_sequencer dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .CONFIG_VALID (CONFIG_VALID),
    .CONFIG_READY (CONFIG_READY),
    .CONFIG_DATA  (CONFIG_DATA),
    .RD_CMD_VALID (RD_CMD_VALID),
    .RD_CMD_READY (crdy[0]),
    .RD_CMD_ADDR  (RD_CMD_ADDR),
    .RD_CMD_LEN   (RD_CMD_LEN),
    .RD_DONE      (cdone[0]),
    .WR_CMD_VALID (WR_CMD_VALID),
    .WR_CMD_READY (crdy[1]),
    .WR_CMD_ADDR  (WR_CMD_ADDR),
    .WR_CMD_LEN   (WR_CMD_LEN),
    .WR_DONE      (cdone[1]),
    .JOB_ERR      (JOB_ERR)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: expected burst list per side, plus issue/outstanding counts.
  logic [31:0] exp_a [2][256];
  logic [3:0]  exp_l [2][256];
  int          n_exp [2];
  int          head  [2];
  int          outst [2];

  task automatic build(input int s, input logic [31:0] base, input logic [31:0] len);
    logic [31:0] a;
    int beats, b, to_page;
    a     = base;
    beats = int'(len / BB);
    n_exp[s] = 0;
    while (beats > 0 && n_exp[s] < 256) begin
      to_page = (4096 - int'(a % 4096)) / BB;
      b = beats;
      if (b > MAXB)    b = MAXB;
      if (b > to_page) b = to_page;
      exp_a[s][n_exp[s]] = a;
      exp_l[s][n_exp[s]] = 4'(b - 1);
      n_exp[s]++;
      a     = a + 32'(b * BB);
      beats = beats - b;
    end
  endtask

  task automatic run_job(input logic [31:0] cmd, input logic [31:0] src,
                         input logic [31:0] dst, input logic [31:0] len,
                         input int rdy_pct, input int done_pct, input int hold_until,
                         input int stall_from, input int reset_at);
    bit err, empty, exp_v, hs, dec, any_dec;
    int cd;
    logic [31:0] pa [2];
    logic [3:0]  pl [2];
    bit pstall [2];
    err   = (cmd[0] && (src % BB != 0)) || (cmd[1] && (dst % BB != 0)) ||
            ((cmd[0] || cmd[1]) && (len % BB != 0));
    empty = (len == 0) || !(cmd[0] || cmd[1]);
    for (int s = 0; s < 2; s++) begin
      n_exp[s] = 0; head[s] = 0; outst[s] = 0; pstall[s] = 0;
    end
    if (!err && !empty) begin
      if (cmd[0]) build(0, src, len);
      if (cmd[1]) build(1, dst, len);
    end

    @(negedge ACLK);
    chk("cfg_ready_idle", CONFIG_READY, 1);
    CONFIG_DATA  = {len, dst, src, cmd};
    CONFIG_VALID = 1'b1;
    crdy = '0; cdone = '0;
    @(negedge ACLK);
    CONFIG_VALID = 1'b0;
    CONFIG_DATA  = {$urandom, $urandom, $urandom, $urandom};
    chk("job_err", JOB_ERR, err);
    cd = (err || empty) ? 2 : -1;

    for (int cyc = 0; ; cyc++) begin
      if (cd > 0) cd--;
      chk("cfg_ready", CONFIG_READY, 32'(cd == 0));
      for (int s = 0; s < 2; s++) begin
        exp_v = (head[s] < n_exp[s]) && (outst[s] < MAXO);
        chk(s ? "wr_valid" : "rd_valid", cv[s], exp_v);
        if (cv[s] && exp_v) begin
          chk(s ? "wr_addr" : "rd_addr", ca[s], exp_a[s][head[s]]);
          chk(s ? "wr_len" : "rd_len", cl[s], exp_l[s][head[s]]);
        end
        if (pstall[s]) begin
          chk(s ? "wr_hold_addr" : "rd_hold_addr", ca[s], pa[s]);
          chk(s ? "wr_hold_len" : "rd_hold_len", cl[s], pl[s]);
        end
      end
      if (cd == 0) break;
      if (cyc >= 3000) begin
        chk("job_timeout", 0, 1);
        break;
      end
      if (cyc == reset_at) begin
        CONFIG_VALID = 1'b0;
        ARESETN = 1'b0;
        #1;
        chk("rst_rd_valid", RD_CMD_VALID, 0);
        chk("rst_wr_valid", WR_CMD_VALID, 0);
        chk("rst_ready", CONFIG_READY, 1);
        chk("rst_rd_addr", RD_CMD_ADDR, 0);
        chk("rst_job_err", JOB_ERR, 0);
        crdy = '1; cdone = '1;
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (4) begin
          @(negedge ACLK);
          chk("post_rst_rd_valid", RD_CMD_VALID, 0);
          chk("post_rst_wr_valid", WR_CMD_VALID, 0);
          chk("post_rst_ready", CONFIG_READY, 1);
        end
        crdy = '0; cdone = '0;
        return;
      end
      any_dec = 0;
      for (int s = 0; s < 2; s++) begin
        exp_v = (head[s] < n_exp[s]) && (outst[s] < MAXO);
        if (s == 0 && stall_from >= 0 && cyc >= stall_from && cyc < stall_from + 5)
          crdy[s] = 1'b0;
        else
          crdy[s] = ($urandom_range(99) < rdy_pct);
        if (cyc < hold_until)  cdone[s] = 1'b0;
        else if (outst[s] > 0) cdone[s] = ($urandom_range(99) < done_pct);
        else                   cdone[s] = ($urandom_range(15) == 0);
        pstall[s] = exp_v && !crdy[s];
        pa[s] = ca[s];
        pl[s] = cl[s];
        hs  = exp_v && crdy[s];
        dec = cdone[s] && (outst[s] > 0);
        if (dec) begin outst[s]--; any_dec = 1; end
        if (hs)  begin head[s]++;  outst[s]++;  end
      end
      CONFIG_VALID = ($urandom_range(3) == 0);
      if (any_dec && cd < 0 && head[0] == n_exp[0] && head[1] == n_exp[1] &&
          outst[0] == 0 && outst[1] == 0)
        cd = 3;
      @(negedge ACLK);
    end
    CONFIG_VALID = 1'b0;
    crdy = '0; cdone = '0;
    chk("job_err_hold", JOB_ERR, err);
    chk("rd_issued", head[0], n_exp[0]);
    chk("wr_issued", head[1], n_exp[1]);
  endtask

  initial begin
    logic [31:0] cmd, src, dst, len;
    ARESETN = 1'b0; CONFIG_VALID = 1'b0; CONFIG_DATA = '0; crdy = '0; cdone = '0;
    repeat (2) @(negedge ACLK);
    chk("reset_ready", CONFIG_READY, 1);
    chk("reset_rd_valid", RD_CMD_VALID, 0);
    chk("reset_wr_valid", WR_CMD_VALID, 0);
    chk("reset_rd_addr", RD_CMD_ADDR, 0);
    chk("reset_wr_len", WR_CMD_LEN, 0);
    chk("reset_job_err", JOB_ERR, 0);
    ARESETN = 1'b1;

    // Stray completions while idle must not produce commands.
    cdone = '1;
    repeat (3) begin
      @(negedge ACLK);
      chk("idle_rd_valid", RD_CMD_VALID, 0);
      chk("idle_wr_valid", WR_CMD_VALID, 0);
    end
    cdone = '0;

    run_job(32'd3, 32'h1000, 32'h2000, 32'd256, 100, 50, 0, -1, -1);
    run_job(32'd1, 32'h0FC0, 32'h0,    32'd128, 70,  60, 0, -1, -1);
    run_job(32'd1, 32'h0,    32'h0,    32'd1024, 100, 100, 30, -1, -1);
    run_job(32'd1, 32'h1004, 32'h0,    32'd64,  100, 50, 0, -1, -1);
    run_job(32'd3, 32'h1000, 32'h2000, 32'd0,   100, 50, 0, -1, -1);
    run_job(32'd0, 32'h1000, 32'h2000, 32'd64,  100, 50, 0, -1, -1);
    run_job(32'd2, 32'h1000, 32'h2003, 32'd64,  100, 50, 0, -1, -1);
    run_job(32'd3, 32'h4000, 32'h8F80, 32'd512, 100, 40, 0, 2, -1);
    run_job(32'd3, 32'h4000, 32'h8000, 32'd1024, 80, 30, 0, -1, 6);
    run_job(32'd2, 32'hFFFF_FF80, 32'hFFFF_FFC0, 32'd256, 90, 50, 0, -1, -1);

    for (int j = 0; j < 25; j++) begin
      cmd = $urandom;
      src = $urandom & ~32'h7;
      dst = $urandom & ~32'h7;
      case ($urandom_range(3))
        0: src = (src & ~32'hFFF) | 32'hF80;
        1: dst = 32'hFFFF_FF00;
        default: ;
      endcase
      len = 32'($urandom_range(256) * BB);
      if ($urandom_range(7) == 0) src = src | 32'h4;
      if ($urandom_range(9) == 0) len = len + 32'd4;
      run_job(cmd, src, dst, len, int'($urandom_range(30, 100)),
              int'($urandom_range(20, 90)), 0, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
